// File: rtl/pwm_capture_pkg.sv
// Shared types and default sizing for the PWM input capture block.
package pwm_capture_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_TIMEOUT = 12000000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchroniser for the asynchronous PWM pin plus a history flop for edge detection.
module pwm_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= pin_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~prev_q;
    assign fall_o  = ~s2_q & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an external PWM pin in clk cycles and flags a stalled input.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             PWM,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] highTime,
    output logic             valid,
    output logic             stalled,
    output logic             level
);

    localparam logic [WIDTH-1:0] TMO     = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic             clear;
    logic             rise;
    logic             fall;
    logic             sync_level;
    state_t           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] hi_lat_q;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] high_q;
    logic             valid_q;
    logic             stalled_q;

    // Disabling the block behaves exactly like reset, synchroniser included.
    assign clear = reset | ~enable;

    pwm_sync_edge u_sync (
        .clk    (clk),
        .reset  (clear),
        .pin_i  (PWM),
        .level_o(sync_level),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != TMO) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        state_q <= ST_LOW;
                    end else if (cnt_q == TMO) begin
                        period_q  <= '0;
                        high_q    <= '0;
                        stalled_q <= 1'b1;
                        valid_q   <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_LOW: begin
                    // A rise on the saturation cycle still counts as a measurement.
                    if (rise) begin
                        period_q  <= cnt_q;
                        high_q    <= hi_lat_q;
                        stalled_q <= 1'b0;
                        valid_q   <= 1'b1;
                        state_q   <= ST_HIGH;
                    end else if (cnt_q == TMO) begin
                        period_q  <= '0;
                        high_q    <= '0;
                        stalled_q <= 1'b1;
                        valid_q   <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_HIGH && fall) begin
            hi_lat_q <= cnt_q;
        end
    end

    assign period   = period_q;
    assign highTime = high_q;
    assign valid    = valid_q;
    assign stalled  = stalled_q;
    assign level    = sync_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed PWM waveforms with a queue of expected measurements checked on every valid pulse.
module tb_pwm_capture;

    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        PWM;
    logic [31:0] period;
    logic [31:0] highTime;
    logic        valid;
    logic        stalled;
    logic        level;

    typedef struct {
        logic [31:0] p;
        logic [31:0] h;
        logic        s;
        bit          gap;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_vcyc = 0;
    logic prev_valid = 1'b0;

    pwm_capture #(.WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .PWM     (PWM),
        .period  (period),
        .highTime(highTime),
        .valid   (valid),
        .stalled (stalled),
        .level   (level)
    );

    always #2 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int p, input int h, input logic s, input bit gap);
        exp_t e;
        e.p = p; e.h = h; e.s = s; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic drive(input logic lvl, input int n);
        PWM = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, period, 0);
        check({tag, "_high"}, highTime, 0);
        check({tag, "_valid"}, {31'd0, valid}, 0);
        check({tag, "_stalled"}, {31'd0, stalled}, 0);
        check({tag, "_level"}, {31'd0, level}, 0);
    endtask

    // Monitor: every valid pulse must match the oldest expected measurement.
    always @(negedge clk) begin
        if (valid) begin
            check("valid_width", {31'd0, prev_valid}, 0);
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: period=%0d high=%0d stalled=%0b, expected no output (cycle %0d)",
                         period, highTime, stalled, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("meas_period", period, e.p);
                check("meas_high", highTime, e.h);
                check("meas_stalled", {31'd0, stalled}, {31'd0, e.s});
                if (e.gap) check("stall_gap", cyc - last_vcyc, TMO);
            end
            last_vcyc = cyc;
        end
        prev_valid = valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; PWM = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 1: period 400, high 100, four cycles
        for (int i = 0; i < 4; i++) begin
            if (i > 0) push_exp(400, 100, 1'b0, 1'b0);
            drive(1'b1, 100);
            drive(1'b0, 300);
        end

        // 2: 50% at period 200, then 10%
        push_exp(400, 100, 1'b0, 1'b0);
        drive(1'b1, 100); drive(1'b0, 100);
        push_exp(200, 100, 1'b0, 1'b0);
        drive(1'b1, 100); drive(1'b0, 100);
        push_exp(200, 100, 1'b0, 1'b0);
        drive(1'b1, 20);
        check("hold_high", highTime, 100);
        check("hold_period", period, 200);
        drive(1'b0, 180);

        // 3: pin held low after a measurement
        push_exp(200, 20, 1'b0, 1'b0);
        push_exp(0, 0, 1'b1, 1'b1);
        drive(1'b1, 20); drive(1'b0, 1100);
        check("stall_low_flag", {31'd0, stalled}, 1);
        drive(1'b1, 50);
        check("stall_after_arm", {31'd0, stalled}, 1);
        drive(1'b0, 150);

        // 4: pin held high, then re-arm
        push_exp(200, 50, 1'b0, 1'b0);
        push_exp(0, 0, 1'b1, 1'b1);
        drive(1'b1, 1100);
        check("stall_high_flag", {31'd0, stalled}, 1);
        drive(1'b0, 100);
        drive(1'b1, 60); drive(1'b0, 140);
        push_exp(200, 60, 1'b0, 1'b0);
        drive(1'b1, 30);

        // 5: one-cycle reset mid-HIGH, pin still high at release
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_zero("midreset");
        drive(1'b1, 20); drive(1'b0, 180);
        push_exp(200, 20, 1'b0, 1'b0);

        // 6: enable drop while running, then rise coincident with saturation
        drive(1'b1, 50); drive(1'b0, 50);
        enable = 1'b0;
        @(negedge clk);
        check_zero("disable");
        drive(1'b1, 100); drive(1'b0, 100);
        drive(1'b1, 50);
        check("disabled_level", {31'd0, level}, 0);
        drive(1'b1, 50); drive(1'b0, 100);
        enable = 1'b1;
        drive(1'b0, 10);
        drive(1'b1, 100); drive(1'b0, 900);
        push_exp(TMO, 100, 1'b0, 1'b0);
        drive(1'b1, 100); drive(1'b0, 50);
        repeat (10) @(negedge clk);

        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
